// File: rtl/matmul_operand_sequencer.sv
// Operand address sequencer for C = A*B over row-major A and B.
// Walks k innermost, then n, then m, using adder-only address stepping.
module matmul_operand_sequencer #(
  parameter int DIM_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  dim_m,
  input  logic [DIM_W-1:0]  dim_k,
  input  logic [DIM_W-1:0]  dim_n,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [DIM_W-1:0]  row_idx,
  output logic [DIM_W-1:0]  col_idx,
  output logic              first_k,
  output logic              last_k
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  localparam logic [DIM_W-1:0]  ONE_D = 1;
  localparam logic [ADDR_W-1:0] ONE_A = 1;

  state_t state, state_nx;

  logic [DIM_W-1:0]  m_dim, k_dim, n_dim;
  logic [DIM_W-1:0]  idx_m, idx_n, idx_k;
  logic [ADDR_W-1:0] base_b_q;
  logic [ADDR_W-1:0] row_a, col_b;
  logic [ADDR_W-1:0] a_q, b_q;
  logic [ADDR_W-1:0] k_step, n_step;

  logic run, xfer, job_ok;
  logic k_end, n_end, m_end;

  assign run    = (state == RUN);
  assign xfer   = run && out_ready;
  assign job_ok = (dim_m != '0) && (dim_k != '0) && (dim_n != '0);

  // Compare against dim-1 so a full-scale dimension never wraps the index.
  assign k_end = (idx_k == k_dim - ONE_D);
  assign n_end = (idx_n == n_dim - ONE_D);
  assign m_end = (idx_m == m_dim - ONE_D);

  assign k_step = ADDR_W'(k_dim);
  assign n_step = ADDR_W'(n_dim);

  assign busy      = run;
  assign out_valid = run;
  assign done      = (state == FIN);
  assign first_k   = run && (idx_k == '0);
  assign last_k    = run && k_end;
  assign addr_a    = a_q;
  assign addr_b    = b_q;
  assign row_idx   = idx_m;
  assign col_idx   = idx_n;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = job_ok ? RUN : FIN;
      RUN:  if (xfer && k_end && n_end && m_end) state_nx = FIN;
      FIN:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // row_a tracks base_a + m*K, col_b tracks base_b + n.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      m_dim    <= '0;
      k_dim    <= '0;
      n_dim    <= '0;
      idx_m    <= '0;
      idx_n    <= '0;
      idx_k    <= '0;
      base_b_q <= '0;
      row_a    <= '0;
      col_b    <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else if (state == IDLE && start && job_ok) begin
      m_dim    <= dim_m;
      k_dim    <= dim_k;
      n_dim    <= dim_n;
      idx_m    <= '0;
      idx_n    <= '0;
      idx_k    <= '0;
      base_b_q <= base_b;
      row_a    <= base_a;
      col_b    <= base_b;
      a_q      <= base_a;
      b_q      <= base_b;
    end else if (xfer) begin
      if (!k_end) begin
        idx_k <= idx_k + ONE_D;
        a_q   <= a_q + ONE_A;
        b_q   <= b_q + n_step;
      end else if (!n_end) begin
        idx_k <= '0;
        idx_n <= idx_n + ONE_D;
        a_q   <= row_a;
        b_q   <= col_b + ONE_A;
        col_b <= col_b + ONE_A;
      end else if (!m_end) begin
        idx_k <= '0;
        idx_n <= '0;
        idx_m <= idx_m + ONE_D;
        row_a <= row_a + k_step;
        a_q   <= row_a + k_step;
        b_q   <= base_b_q;
        col_b <= base_b_q;
      end
    end
  end

endmodule

// File: doc/matmul_operand_sequencer.md
MATMUL_OPERAND_SEQUENCER -- requirements
Module: matmul_operand_sequencer

Interface
REQ-001 SHALL have parameter DIM_W, default 16, width of each matrix dimension and of the row/column indices.
REQ-002 SHALL have parameter ADDR_W, default 32, width of element-granular operand addresses.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-high (asserted = 1).
REQ-005 SHALL have port start, input, 1, one-cycle job request, sampled only in IDLE.
REQ-006 SHALL have ports dim_m, dim_k, dim_n, input, DIM_W each: M, K, N of C[MxN] = A[MxK] * B[KxN]; captured with start.
REQ-007 SHALL have ports base_a, base_b, input, ADDR_W each: element base addresses of row-major A and B; captured with start.
REQ-008 SHALL have port busy, output, 1, high in RUN.
REQ-009 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port out_valid, output, 1, operand tuple valid toward the downstream matmul datapath.
REQ-011 SHALL have port out_ready, input, 1, downstream accept.
REQ-012 SHALL have ports addr_a, addr_b, output, ADDR_W each: addresses of A[m][k] and B[k][n].
REQ-013 SHALL have ports row_idx, col_idx, output, DIM_W each: current m and n of the C element being formed.
REQ-014 SHALL have ports first_k, last_k, output, 1 each: tuple is k==0 / k==K-1 of its dot product.

Function
REQ-015 SHALL implement states IDLE, RUN, FIN.
REQ-016 IDLE + start=1 with M, K, N all nonzero SHALL latch dims/bases, zero m, n, k, and enter RUN next cycle with out_valid=1 presenting m=0, n=0, k=0.
REQ-017 IDLE + start=1 with any of M, K, N zero SHALL enter FIN directly, issuing no tuple.
REQ-018 Iteration order SHALL be k innermost, n middle, m outermost; exactly M*N*K tuples per job.
REQ-019 A tuple SHALL transfer only in a cycle with out_valid=1 and out_ready=1; the next tuple appears the following cycle, giving one tuple per cycle under continuous ready.
REQ-020 While out_valid=1 and out_ready=0, all tuple outputs SHALL hold stable.
REQ-021 addr_a SHALL equal base_a + m*K + k and addr_b SHALL equal base_b + k*N + n, modulo 2^ADDR_W, computed incrementally with adders only (no multipliers).
REQ-022 first_k SHALL be 1 iff k==0; last_k SHALL be 1 iff k==K-1; both 1 when K==1.
REQ-023 Transfer of the tuple with m=M-1, n=N-1, k=K-1 SHALL move to FIN; out_valid SHALL be 0 the next cycle.
REQ-024 FIN SHALL assert done for exactly one cycle, then return to IDLE.
REQ-025 start while in RUN or FIN SHALL be ignored; captured dims/bases SHALL not change mid-job.
REQ-026 busy SHALL be 1 exactly while in RUN; done and busy SHALL never be 1 together.
REQ-027 Dimension value 2^DIM_W-1 SHALL be supported without index overflow.

Reset
REQ-028 rst_n=1 SHALL immediately force IDLE, out_valid=0, busy=0, done=0, first_k=0, last_k=0, addr_a=0, addr_b=0, row_idx=0, col_idx=0, regardless of clock.
REQ-029 Reset asserted mid-job SHALL abandon the job with no done pulse; first start after release SHALL begin a fresh job.

Verification
REQ-030 M=2,K=3,N=2, base_a=0x100, base_b=0x200, out_ready=1 -> 12 consecutive tuples; addr_a 0x100,101,102,100,101,102,103,104,105,103,104,105; addr_b 0x200,202,204,201,203,205 repeated; done one cycle after the 12th.
REQ-031 Same job, out_ready toggling 1,0,0,1,... -> identical 12-tuple sequence, outputs frozen during every ready=0 cycle, no tuple duplicated or dropped.
REQ-032 M=1,K=1,N=1 -> single tuple with first_k=1, last_k=1, row_idx=0, col_idx=0; done next cycle.
REQ-033 start with K=0 (M=N=4) -> no out_valid, done pulses one cycle after start's capture, busy stays 0.
REQ-034 rst_n pulsed high after 5 tuples of a 2x3x2 job -> all outputs 0 asynchronously, no done; new start after release -> sequence restarts from addr_a=base_a.
REQ-035 start re-asserted with different dims during RUN -> ignored; original job completes with original sequence.
